ram_sdp_pipe: RTL

RAM_SDP_PIPE -- requirements
Module: ram_sdp_pipe

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_sdp_be_core.sv | 51 +++++
 rtl/ram_sdp_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port pipelined RAM.
package ram_pkg;

    // Controller state. busy on the top level is a direct view of this.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Supported read latencies, in clock cycles.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // True when a requested read latency can be built.
    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_sdp_be_core.sv
// Byte-enable write / registered read memory core, one-cycle read latency.
// Out-of-range addresses drop writes and read back as zero.
module ram_sdp_be_core #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 32,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int BWIDTH = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [BWIDTH-1:0] wbe,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

    // Array contents are only ever defined by writes; no reset on purpose.
    logic [DWIDTH-1:0] mem [DEPTH];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

    // Byte-granular write; disabled lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            for (int i = 0; i < BWIDTH; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-before-write output register; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= raddr_ok ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/ram_sdp_pipe.sv
// Pipelined simple-dual-port RAM with power-up / on-demand zero-fill,
// optional write-to-read collision bypass and one or two read stages.
//
// Handshake: a read is accepted on any rising edge where enb=1 and busy=0;
// exactly RD_LAT edges later dob_vld is high for one cycle with the data.
// There is no back-pressure. Writes and reads presented while busy=1 are
// ignored. dob holds its last value whenever dob_vld=0.
module ram_sdp_pipe
    import ram_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 0,
    localparam int AWIDTH = $clog2(DEPTH),
    localparam int BWIDTH = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [BWIDTH-1:0] wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    input  logic              clear_req,
    output logic [DWIDTH-1:0] dob,
    output logic              dob_vld,
    output logic              busy
);

    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    if (!rd_lat_legal(RD_LAT) || (DWIDTH % 8 != 0) || (DWIDTH < 8) || (DEPTH < 2)) begin : g_bad_param
        $error("ram_sdp_pipe: illegal parameters (RD_LAT must be 1 or 2, DWIDTH a multiple of 8, DEPTH >= 2)");
    end

    ram_state_e        state;
    logic [AWIDTH-1:0] clr_addr;

    logic              rd_acc;
    logic              wr_in_range;
    logic              core_we;
    logic [AWIDTH-1:0] core_waddr;
    logic [BWIDTH-1:0] core_wbe;
    logic [DWIDTH-1:0] core_wdata;
    logic [DWIDTH-1:0] core_rdata;
    logic [BWIDTH-1:0] byp_mask_q;
    logic [DWIDTH-1:0] byp_data_q;
    logic [DWIDTH-1:0] rd_merged;
    logic              vld1_q;

    assign rd_acc      = enb && (state == READY);
    assign wr_in_range = ({1'b0, addra} < DEPTH_W);
    // busy is the externally visible copy of the controller state.
    assign busy        = (state == CLEAR);

    // Controller: sweep zeros through the array, then serve the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= READY;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Write port mux: the clear sweep owns the write port while busy.
    always_comb begin
        core_we    = 1'b0;
        core_waddr = addra;
        core_wbe   = wea;
        core_wdata = dia;
        if (state == CLEAR) begin
            core_we    = 1'b1;
            core_waddr = clr_addr;
            core_wbe   = '1;
            core_wdata = '0;
        end else begin
            core_we    = ena;
        end
    end

    ram_sdp_be_core #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (core_we),
        .waddr (core_waddr),
        .wbe   (core_wbe),
        .wdata (core_wdata),
        .re    (rd_acc),
        .raddr (addrb),
        .rdata (core_rdata)
    );

    // Capture which bytes a same-address write is changing alongside the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else if (rd_acc) begin
            byp_mask_q <= ((BYPASS != 0) && ena && wr_in_range && (addra == addrb)) ? wea : '0;
            byp_data_q <= dia;
        end
    end

    // Overlay the bypassed bytes onto the core's pre-write word.
    always_comb begin
        rd_merged = core_rdata;
        for (int i = 0; i < BWIDTH; i++) begin
            if (byp_mask_q[i]) begin
                rd_merged[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    // First valid stage tracks the core's registered read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= rd_acc;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign dob     = rd_merged;
        assign dob_vld = vld1_q;
    end else begin : g_lat2
        logic              vld2_q;
        logic [DWIDTH-1:0] dob_q;

        // Second output stage; only loads when a result is arriving.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld2_q <= 1'b0;
                dob_q  <= '0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    dob_q <= rd_merged;
                end
            end
        end

        assign dob     = dob_q;
        assign dob_vld = vld2_q;
    end

endmodule
